ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports valid_i/stall_i/flush_i  input  1 each  ID/EX valid, hold request, kill request.
REQ-005 SHALL have port alu_control_i  input  4  encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt, 1010 sll.
REQ-006 SHALL have ports rs1_data_i/rs2_data_i/imm_i  input  XLEN each  register operands and immediate.
REQ-007 SHALL have port alu_src_b_i  input  1  selects imm_i (1) or forwarded rs2 (0) as operand B.
REQ-008 SHALL have ports fwd_a_i/fwd_b_i  input  2 each  forwarding select: 00 register, 01 wb_result_i, 10 mem_result_i, 11 register.
REQ-009 SHALL have ports mem_result_i/wb_result_i  input  XLEN each  forwarded results.
REQ-010 SHALL have ports rd_i  input  5 and reg_write_i  input  1  destination and write enable.
REQ-011 SHALL have outputs valid_o 1, alu_result_o XLEN, zero_o 1, store_data_o XLEN, rd_o 5, reg_write_o 1, illegal_op_o 1  registered EX/MEM fields.

Function
REQ-012 SHALL compute the ALU result combinationally and register every output on the rising clk edge: one-cycle latency.
REQ-013 SHALL wrap add/sub modulo 2^XLEN without overflow indication.
REQ-014 SHALL compute slt as a signed comparison, producing 1 or 0 zero-extended to XLEN.
REQ-015 SHALL compute sll as A shifted left by B[4:0].
REQ-016 SHALL set zero_o to 1 exactly when the registered alu_result_o equals 0.
REQ-017 SHALL set store_data_o to the forwarded rs2 value, regardless of alu_src_b_i.
REQ-018 SHALL, for any other alu_control_i code with valid_i=1, register alu_result_o=0, reg_write_o=0, illegal_op_o=1.
REQ-019 SHALL set illegal_op_o as a one-cycle pulse per offending instruction, not sticky.
REQ-020 SHALL hold all outputs unchanged while stall_i=1 and flush_i=0.
REQ-021 SHALL, on flush_i=1, register valid_o=0, reg_write_o=0 and illegal_op_o=0; flush overrides stall.
REQ-022 SHALL force reg_write_o=0 and illegal_op_o=0 whenever the captured valid_i is 0.

Reset
REQ-023 SHALL, on rst_n low, immediately clear all outputs to 0, independent of clk.
REQ-024 SHALL, after rst_n deasserts, capture normally from the first rising clk edge.
REQ-025 SHALL discard an instruction in flight when reset asserts; it is never re-emitted.

Configuration
REQ-026 SHALL, with EX_FORWARD_EN defined, implement the fwd_a_i/fwd_b_i muxes per REQ-008.
REQ-027 SHALL, without EX_FORWARD_EN, use rs1_data_i/rs2_data_i directly; fwd_*_i, mem_result_i and wb_result_i are ignored but the ports remain.

Structure
REQ-028 SHALL take ALU control encodings and forwarding select constants from shared package riscv_pkg.
REQ-029 SHALL instantiate the arithmetic as sub-module alu (operands, alu_control, result, illegal flag), purely combinational.

Verification
REQ-030 SHALL cover: add 0x7FFFFFFF+1 -> alu_result_o=0x80000000 one cycle later; sub 5-5 -> result 0, zero_o=1.
REQ-031 SHALL cover: slt A=0xFFFFFFFF, B=1 -> result 1; sll A=1, B=0x23 -> result 0x8.
REQ-032 SHALL cover: fwd_a_i=10, mem_result_i=0x10, rs1=0x99, B=imm 4, add -> result 0x14; same with EX_FORWARD_EN undefined -> 0x9D.
REQ-033 SHALL cover: stall_i=1 for 3 cycles -> outputs frozen; stall_i=1 with flush_i=1 -> valid_o=0 and reg_write_o=0 next cycle.
REQ-034 SHALL cover: alu_control_i=0111, valid_i=1, reg_write_i=1 -> illegal_op_o=1 for one cycle, reg_write_o=0, result 0.
REQ-035 SHALL cover: rst_n pulled low mid-operation between clk edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the execute stage: ALU operation encodings and
// forwarding-select codes.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_SLT = 4'b0101,
      ALU_SLL = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG     = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10,
      FWD_REG_ALT = 2'b11
   } fwd_sel_e;

   // shift amount field width taken from operand B
   localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU for the execute stage. Unknown operation codes
// produce a zero result and raise the illegal flag.
module alu
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      alu_control,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   // operation decode; add/sub wrap modulo 2^XLEN, slt is signed
   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (alu_control)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL: result = a << b[SHAMT_W-1:0];
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand selection, ALU, and the EX/MEM output register.
// Optional feature macro: EX_FORWARD_EN enables the forwarding muxes on
// operands A and B; without it the register operands are used directly.
module ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [3:0]      alu_control_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            alu_src_b_i,
   input  logic [1:0]      fwd_a_i,
   input  logic [1:0]      fwd_b_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic [XLEN-1:0] wb_result_i,
   input  logic [4:0]      rd_i,
   input  logic            reg_write_i,
   output logic            valid_o,
   output logic [XLEN-1:0] alu_result_o,
   output logic            zero_o,
   output logic [XLEN-1:0] store_data_o,
   output logic [4:0]      rd_o,
   output logic            reg_write_o,
   output logic            illegal_op_o
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic            alu_illegal;

`ifdef EX_FORWARD_EN
   // forwarding muxes: both 00 and 11 select the register file value
   always_comb begin
      op_a    = rs1_data_i;
      rs2_fwd = rs2_data_i;
      case (fwd_a_i)
         FWD_WB:  op_a = wb_result_i;
         FWD_MEM: op_a = mem_result_i;
         default: op_a = rs1_data_i;
      endcase
      case (fwd_b_i)
         FWD_WB:  rs2_fwd = wb_result_i;
         FWD_MEM: rs2_fwd = mem_result_i;
         default: rs2_fwd = rs2_data_i;
      endcase
   end
`else
   // forwarding ports stay on the interface but are not consumed
   logic unused_fwd;
   assign unused_fwd = ^{fwd_a_i, fwd_b_i, mem_result_i, wb_result_i};
   assign op_a       = rs1_data_i;
   assign rs2_fwd    = rs2_data_i;
`endif

   // store data always follows the forwarded rs2, independent of operand B select
   assign op_b = alu_src_b_i ? imm_i : rs2_fwd;

   alu #(.XLEN(XLEN)) u_alu (
      .a           (op_a),
      .b           (op_b),
      .alu_control (alu_control_i),
      .result      (alu_res),
      .illegal     (alu_illegal)
   );

   // EX/MEM register: flush kills control bits (wins over stall), stall holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o      <= 1'b0;
         alu_result_o <= '0;
         zero_o       <= 1'b0;
         store_data_o <= '0;
         rd_o         <= 5'd0;
         reg_write_o  <= 1'b0;
         illegal_op_o <= 1'b0;
      end else if (flush_i) begin
         valid_o      <= 1'b0;
         reg_write_o  <= 1'b0;
         illegal_op_o <= 1'b0;
      end else if (!stall_i) begin
         valid_o      <= valid_i;
         alu_result_o <= alu_res;
         zero_o       <= (alu_res == '0);
         store_data_o <= rs2_fwd;
         rd_o         <= rd_i;
         reg_write_o  <= valid_i & reg_write_i & ~alu_illegal;
         illegal_op_o <= valid_i & alu_illegal;
      end
   end

endmodule
